ctrl_unit_p: RTL and testbench

CTRL_UNIT_P -- requirements
Module: ctrl_unit_p

---
 rtl/kx_ctrl_pkg.sv | 38 +++
 rtl/ctrl_unit_p_if.sv | 39 +++
 rtl/ctrl_mem_wait.sv | 30 +++
 rtl/ctrl_unit_p.sv | 146 ++++++++++++++
 tb/tb_ctrl_unit_p.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/kx_ctrl_pkg.sv
// Shared opcode, ALU/shifter select codes and controller state encoding
// for the kx control unit and its helpers.
package kx_ctrl_pkg;

   localparam logic [4:0] OPC_NOP  = 5'b00000;
   localparam logic [4:0] OPC_LD   = 5'b00001;
   localparam logic [4:0] OPC_STA  = 5'b00010;
   localparam logic [4:0] OPC_MOV  = 5'b00011;
   localparam logic [4:0] OPC_LDI  = 5'b00100;
   localparam logic [4:0] OPC_INC  = 5'b00111;
   localparam logic [4:0] OPC_ADD  = 5'b01101;
   localparam logic [4:0] OPC_BRA  = 5'b10000;
   localparam logic [4:0] OPC_BRC  = 5'b10001;
   localparam logic [4:0] OPC_HALT = 5'b11111;

   localparam logic [3:0] ALU_PASS = 4'd0;
   localparam logic [3:0] ALU_PLUS = 4'd5;
   localparam logic [3:0] ALU_INC  = 4'd7;
   localparam logic [3:0] ALU_ZERO = 4'd9;

   localparam logic [2:0] SHIFT_PASS = 3'd0;

   // Encodings 28..31 are unused and recover to S_INC_PC.
   typedef enum logic [4:0] {
      S_RST1    = 5'd0,  S_RST2   = 5'd1,  S_RST3  = 5'd2,  S_EXEC    = 5'd3,
      S_LD2     = 5'd4,  S_LD3    = 5'd5,  S_ST2   = 5'd6,  S_ST3     = 5'd7,
      S_MOV1    = 5'd8,  S_MOV2   = 5'd9,  S_LDI2  = 5'd10, S_LDI3    = 5'd11,
      S_LDI4    = 5'd12, S_INC2   = 5'd13, S_INC3  = 5'd14, S_ADD2    = 5'd15,
      S_ADD3    = 5'd16, S_ADD4   = 5'd17, S_BR2   = 5'd18, S_BR3     = 5'd19,
      S_BR4     = 5'd20, S_BRC2   = 5'd21, S_BRC3  = 5'd22, S_INC_PC  = 5'd23,
      S_INC_PC2 = 5'd24, S_INC_PC3 = 5'd25, S_FETCH = 5'd26, S_HALT   = 5'd27
   } ctrl_state_e;

   function automatic logic isVmaState(ctrl_state_e s);
      return s inside {S_RST3, S_LD3, S_ST3, S_LDI4, S_BR4, S_INC_PC3};
   endfunction

endpackage

// File: rtl/ctrl_unit_p_if.sv
// Control bus between the kx controller (master) and its datapath (slave).
interface ctrl_unit_p_if #(
   parameter int DATA_W = 16,
   parameter int RSEL_W = 3
);
   // Memory handshake: the master holds vma (and rw, address strobes) steady
   // until the slave answers with mem_ready=1; the transfer completes in that
   // cycle, and register write strobes are only asserted in it.
   logic [DATA_W-1:0] instr_reg;
   logic              compout;
   logic              mem_ready;

   logic              prog_cntr_wr, prog_cntr_rd;
   logic              addr_reg_wr,  addr_reg_rd;
   logic              out_reg_wr,   out_reg_rd;
   logic              op_reg_wr,    op_reg_rd;
   logic              instr_wr, reg_rd, reg_wr, rw, vma;
   logic [2:0]        shift_sel;
   logic [3:0]        alu_sel;
   logic [2:0]        comp_sel;
   logic [RSEL_W-1:0] reg_sel;
   logic              halted, mem_fault;

   modport master (
      input  instr_reg, compout, mem_ready,
      output prog_cntr_wr, prog_cntr_rd, addr_reg_wr, addr_reg_rd,
             out_reg_wr, out_reg_rd, op_reg_wr, op_reg_rd,
             instr_wr, reg_rd, reg_wr, rw, vma,
             shift_sel, alu_sel, comp_sel, reg_sel, halted, mem_fault
   );

   modport slave (
      output instr_reg, compout, mem_ready,
      input  prog_cntr_wr, prog_cntr_rd, addr_reg_wr, addr_reg_rd,
             out_reg_wr, out_reg_rd, op_reg_wr, op_reg_rd,
             instr_wr, reg_rd, reg_wr, rw, vma,
             shift_sel, alu_sel, comp_sel, reg_sel, halted, mem_fault
   );
endinterface

// File: rtl/ctrl_mem_wait.sv
// Memory wait-state watchdog: counts stalled cycles in a vma state and
// raises a one-cycle timeout plus a sticky mem_fault.
module ctrl_mem_wait #(
   parameter int WAIT_MAX = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic vma_state,
   input  logic mem_ready,
   output logic timeout,
   output logic mem_fault
);
   localparam int CNT_W = $clog2(WAIT_MAX + 1);

   logic [CNT_W-1:0] waitCnt;

   // Fires on the WAIT_MAX-th consecutive cycle without mem_ready.
   assign timeout = vma_state && !mem_ready && (waitCnt == CNT_W'(WAIT_MAX - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         waitCnt   <= '0;
         mem_fault <= 1'b0;
      end else begin
         if (!vma_state || mem_ready || timeout) waitCnt <= '0;
         else                                    waitCnt <= waitCnt + 1'b1;
         if (timeout) mem_fault <= 1'b1;
      end
   end
endmodule

// File: rtl/ctrl_unit_p.sv
// Microsequenced control unit for the kx core: resets, fetches, decodes and
// steps each instruction through its datapath strobe sequence.
module ctrl_unit_p
   import kx_ctrl_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int OPC_W    = 5,
   parameter int RSEL_W   = 3,
   parameter int ACC_REG  = 3,
   parameter int WAIT_MAX = 15
) (
   input  logic          clock,
   input  logic          reset,
   ctrl_unit_p_if.master bus,
   output ctrl_state_e   debugState
);
   ctrl_state_e       state, nextState;
   logic              skipPend, skipNext;
   logic              vmaState, timeout, memFault;
   logic [OPC_W-1:0]  opcode;
   logic [RSEL_W-1:0] srcSel, dstSel;
   logic              unusedInstr;

   logic              progCntrWr, progCntrRd, addrRegWr, outRegWr, outRegRd;
   logic              opRegWr, instrWr, regRd, regWr, rwOut, vmaOut, halted;
   logic [3:0]        aluSel;
   logic [RSEL_W-1:0] regSel;

   assign opcode      = bus.instr_reg[DATA_W-1 -: OPC_W];
   assign srcSel      = bus.instr_reg[2*RSEL_W-1:RSEL_W];
   assign dstSel      = bus.instr_reg[RSEL_W-1:0];
   assign unusedInstr = ^bus.instr_reg;
   assign vmaState    = isVmaState(state);
   assign debugState  = state;

   ctrl_mem_wait #(.WAIT_MAX(WAIT_MAX)) u_mem_wait (
      .clock     (clock),
      .reset     (reset),
      .vma_state (vmaState),
      .mem_ready (bus.mem_ready),
      .timeout   (timeout),
      .mem_fault (memFault)
   );

   // skipPend makes a failed BRC run the PC increment twice before fetching.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= S_RST1;
         skipPend <= 1'b0;
      end else begin
         state    <= nextState;
         skipPend <= skipNext;
      end
   end

   always_comb begin
      nextState  = state;
      skipNext   = skipPend;
      progCntrWr = 1'b0; progCntrRd = 1'b0; addrRegWr = 1'b0;
      outRegWr   = 1'b0; outRegRd   = 1'b0; opRegWr   = 1'b0;
      instrWr    = 1'b0; regRd      = 1'b0; regWr     = 1'b0;
      rwOut      = 1'b0; vmaOut     = 1'b0; halted    = 1'b0;
      aluSel     = ALU_PASS;
      regSel     = '0;
      case (state)
         S_RST1:    begin aluSel = ALU_ZERO; outRegWr = 1'b1; nextState = S_RST2; end
         S_RST2:    begin outRegRd = 1'b1; progCntrWr = 1'b1; addrRegWr = 1'b1; nextState = S_RST3; end
         S_RST3:    begin vmaOut = 1'b1; instrWr = bus.mem_ready; nextState = S_EXEC; end
         S_EXEC: begin
            case (opcode)
               OPC_W'(OPC_NOP):  nextState = S_INC_PC;
               OPC_W'(OPC_LD):   nextState = S_LD2;
               OPC_W'(OPC_STA):  nextState = S_ST2;
               OPC_W'(OPC_MOV):  nextState = S_MOV1;
               OPC_W'(OPC_LDI):  nextState = S_LDI2;
               OPC_W'(OPC_INC):  nextState = S_INC2;
               OPC_W'(OPC_ADD):  nextState = S_ADD2;
               OPC_W'(OPC_BRA):  nextState = S_BR2;
               OPC_W'(OPC_BRC):  nextState = S_BRC2;
               OPC_W'(OPC_HALT): nextState = S_HALT;
               default:          nextState = S_INC_PC;
            endcase
         end
         S_LD2:     begin regSel = srcSel; regRd = 1'b1; addrRegWr = 1'b1; nextState = S_LD3; end
         S_LD3:     begin vmaOut = 1'b1; regSel = dstSel; regWr = bus.mem_ready; nextState = S_INC_PC; end
         S_ST2:     begin regSel = dstSel; regRd = 1'b1; addrRegWr = 1'b1; nextState = S_ST3; end
         S_ST3:     begin regSel = srcSel; regRd = 1'b1; vmaOut = 1'b1; rwOut = 1'b1; nextState = S_INC_PC; end
         S_MOV1:    begin regSel = srcSel; regRd = 1'b1; outRegWr = 1'b1; nextState = S_MOV2; end
         S_MOV2:    begin regSel = dstSel; outRegRd = 1'b1; regWr = 1'b1; nextState = S_INC_PC; end
         S_ADD2:    begin regSel = srcSel; regRd = 1'b1; opRegWr = 1'b1; nextState = S_ADD3; end
         S_ADD3:    begin regSel = dstSel; regRd = 1'b1; aluSel = ALU_PLUS; outRegWr = 1'b1; nextState = S_ADD4; end
         S_ADD4:    begin regSel = RSEL_W'(ACC_REG); outRegRd = 1'b1; regWr = 1'b1; nextState = S_INC_PC; end
         S_INC2:    begin regSel = dstSel; regRd = 1'b1; aluSel = ALU_INC; outRegWr = 1'b1; nextState = S_INC3; end
         S_INC3:    begin regSel = dstSel; outRegRd = 1'b1; regWr = 1'b1; nextState = S_INC_PC; end
         S_LDI2:    begin progCntrRd = 1'b1; aluSel = ALU_INC; outRegWr = 1'b1; nextState = S_LDI3; end
         S_LDI3:    begin outRegRd = 1'b1; progCntrWr = 1'b1; addrRegWr = 1'b1; nextState = S_LDI4; end
         S_LDI4:    begin vmaOut = 1'b1; regSel = dstSel; regWr = bus.mem_ready; nextState = S_INC_PC; end
         S_BR2:     begin progCntrRd = 1'b1; aluSel = ALU_INC; outRegWr = 1'b1; nextState = S_BR3; end
         S_BR3:     begin outRegRd = 1'b1; addrRegWr = 1'b1; nextState = S_BR4; end
         S_BR4:     begin vmaOut = 1'b1; progCntrWr = bus.mem_ready; nextState = S_FETCH; end
         S_FETCH:   begin progCntrRd = 1'b1; addrRegWr = 1'b1; nextState = S_INC_PC3; end
         S_BRC2:    begin regSel = srcSel; regRd = 1'b1; opRegWr = 1'b1; nextState = S_BRC3; end
         S_BRC3: begin
            regSel = dstSel;
            regRd  = 1'b1;
            if (bus.compout) nextState = S_BR2;
            else begin
               nextState = S_INC_PC;
               skipNext  = 1'b1;
            end
         end
         S_INC_PC:  begin progCntrRd = 1'b1; aluSel = ALU_INC; outRegWr = 1'b1; nextState = S_INC_PC2; end
         S_INC_PC2: begin
            outRegRd   = 1'b1;
            progCntrWr = 1'b1;
            addrRegWr  = 1'b1;
            nextState  = skipPend ? S_INC_PC : S_INC_PC3;
            skipNext   = 1'b0;
         end
         S_INC_PC3: begin vmaOut = 1'b1; instrWr = bus.mem_ready; nextState = S_EXEC; end
         S_HALT:    begin halted = 1'b1; nextState = S_HALT; end
         default:   nextState = S_INC_PC;
      endcase
      if (vmaState && !bus.mem_ready) nextState = timeout ? S_HALT : state;
   end

   assign bus.prog_cntr_wr = progCntrWr;
   assign bus.prog_cntr_rd = progCntrRd;
   assign bus.addr_reg_wr  = addrRegWr;
   assign bus.addr_reg_rd  = 1'b0;
   assign bus.out_reg_wr   = outRegWr;
   assign bus.out_reg_rd   = outRegRd;
   assign bus.op_reg_wr    = opRegWr;
   assign bus.op_reg_rd    = 1'b0;
   assign bus.instr_wr     = instrWr;
   assign bus.reg_rd       = regRd;
   assign bus.reg_wr       = regWr;
   assign bus.rw           = rwOut;
   assign bus.vma          = vmaOut;
   assign bus.shift_sel    = SHIFT_PASS;
   assign bus.alu_sel      = aluSel;
   assign bus.comp_sel     = bus.instr_reg[2*RSEL_W+2:2*RSEL_W];
   assign bus.reg_sel      = regSel;
   assign bus.halted       = halted;
   assign bus.mem_fault    = memFault;
endmodule

// File: tb/tb_ctrl_unit_p.sv
// Directed bench for ctrl_unit_p: per-cycle expected output words are queued
// as each step is driven and compared once the cycle's outputs settle.
module tb_ctrl_unit_p;
   import kx_ctrl_pkg::*;

   localparam int OBS_W = 33;
   localparam logic [14:0] F_PCWR = 15'h4000, F_PCRD = 15'h2000, F_ARWR = 15'h1000;
   localparam logic [14:0] F_ARRD = 15'h0800, F_ORWR = 15'h0400, F_ORRD = 15'h0200;
   localparam logic [14:0] F_OPWR = 15'h0100, F_OPRD = 15'h0080, F_IWR  = 15'h0040;
   localparam logic [14:0] F_RRD  = 15'h0020, F_RWR  = 15'h0010, F_RW   = 15'h0008;
   localparam logic [14:0] F_VMA  = 15'h0004, F_HLT  = 15'h0002, F_MF   = 15'h0001;
   localparam logic [3:0]  A_PASS = 4'd0, A_PLUS = 4'd5, A_INC = 4'd7, A_ZERO = 4'd9;

   logic clock;
   logic reset;
   ctrl_state_e debugState;
   ctrl_unit_p_if #(.DATA_W(16), .RSEL_W(3)) bus ();

   ctrl_unit_p dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .debugState (debugState)
   );

   // Clock and reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   logic [OBS_W-1:0] exp_q[$];
   logic [2:0]       curCs;
   logic [OBS_W-1:0] obsVec;

   assign obsVec = {debugState, bus.reg_sel, bus.alu_sel, bus.shift_sel, bus.comp_sel,
                    bus.prog_cntr_wr, bus.prog_cntr_rd, bus.addr_reg_wr, bus.addr_reg_rd,
                    bus.out_reg_wr, bus.out_reg_rd, bus.op_reg_wr, bus.op_reg_rd,
                    bus.instr_wr, bus.reg_rd, bus.reg_wr, bus.rw, bus.vma,
                    bus.halted, bus.mem_fault};

   function automatic logic [OBS_W-1:0] ev(ctrl_state_e s, logic [2:0] rs, logic [3:0] alu,
                                           logic [14:0] fl);
      return {s, rs, alu, 3'b000, curCs, fl};
   endfunction

   function automatic logic [15:0] mk(logic [4:0] opc, logic [2:0] cs, logic [2:0] s,
                                      logic [2:0] d);
      return {opc, 2'b00, cs, s, d};
   endfunction

   // Driver tasks
   task automatic set_instr(input logic [15:0] v);
      bus.instr_reg = v;
      curCs         = v[8:6];
   endtask

   task automatic step(input string tag, input logic [OBS_W-1:0] e, input logic mr,
                       input logic cmp);
      logic [OBS_W-1:0] got;
      logic [OBS_W-1:0] want;
      bus.mem_ready = mr;
      bus.compout   = cmp;
      exp_q.push_back(e);
      #1;
      got  = obsVec;
      want = exp_q.pop_front();
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, want);
      end
      @(negedge clock);
   endtask

   task automatic fetch_tail(input logic [15:0] nxt);
      step("inc_pc",  ev(S_INC_PC,  0, A_INC,  F_PCRD | F_ORWR), 1'b1, 1'b0);
      step("inc_pc2", ev(S_INC_PC2, 0, A_PASS, F_ORRD | F_PCWR | F_ARWR), 1'b1, 1'b0);
      step("inc_pc3", ev(S_INC_PC3, 0, A_PASS, F_VMA | F_IWR), 1'b1, 1'b0);
      set_instr(nxt);
      step("exec",    ev(S_EXEC,    0, A_PASS, '0), 1'b1, 1'b0);
   endtask

   task automatic reset_seq;
      step("rst1", ev(S_RST1, 0, A_ZERO, F_ORWR), 1'b1, 1'b0);
      step("rst2", ev(S_RST2, 0, A_PASS, F_ORRD | F_PCWR | F_ARWR), 1'b1, 1'b0);
      step("rst3", ev(S_RST3, 0, A_PASS, F_VMA | F_IWR), 1'b1, 1'b0);
      step("exec", ev(S_EXEC, 0, A_PASS, '0), 1'b1, 1'b0);
   endtask

   initial begin
      reset         = 1'b1;
      bus.mem_ready = 1'b1;
      bus.compout   = 1'b0;
      set_instr(16'h6819);
      @(negedge clock);
      step("reset_hold", ev(S_RST1, 0, A_ZERO, F_ORWR), 1'b1, 1'b0);
      step("reset_hold", ev(S_RST1, 0, A_ZERO, F_ORWR), 1'b1, 1'b0);
      reset = 1'b0;
      reset_seq();

      // ADD src=3 dst=1, result into register 3
      step("add2", ev(S_ADD2, 3, A_PASS, F_RRD | F_OPWR), 1'b1, 1'b0);
      step("add3", ev(S_ADD3, 1, A_PLUS, F_RRD | F_ORWR), 1'b1, 1'b0);
      step("add4", ev(S_ADD4, 3, A_PASS, F_ORRD | F_RWR), 1'b1, 1'b0);
      fetch_tail(mk(5'b00001, 3'd5, 3'd2, 3'd5));

      // LD with three wait states
      step("ld2", ev(S_LD2, 2, A_PASS, F_RRD | F_ARWR), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step("ld3_wait", ev(S_LD3, 5, A_PASS, F_VMA), 1'b0, 1'b0);
      step("ld3_done", ev(S_LD3, 5, A_PASS, F_VMA | F_RWR), 1'b1, 1'b0);
      fetch_tail(mk(5'b00010, 3'd2, 3'd4, 3'd6));

      step("st2", ev(S_ST2, 6, A_PASS, F_RRD | F_ARWR), 1'b1, 1'b0);
      step("st3", ev(S_ST3, 4, A_PASS, F_RRD | F_VMA | F_RW), 1'b1, 1'b0);
      fetch_tail(mk(5'b10001, 3'd7, 3'd1, 3'd2));

      // BRC taken
      step("brc2", ev(S_BRC2, 1, A_PASS, F_RRD | F_OPWR), 1'b1, 1'b0);
      step("brc3_t", ev(S_BRC3, 2, A_PASS, F_RRD), 1'b1, 1'b1);
      step("br2", ev(S_BR2, 0, A_INC, F_PCRD | F_ORWR), 1'b1, 1'b0);
      step("br3", ev(S_BR3, 0, A_PASS, F_ORRD | F_ARWR), 1'b1, 1'b0);
      step("br4_wait", ev(S_BR4, 0, A_PASS, F_VMA), 1'b0, 1'b0);
      step("br4_done", ev(S_BR4, 0, A_PASS, F_VMA | F_PCWR), 1'b1, 1'b0);
      step("fetch", ev(S_FETCH, 0, A_PASS, F_PCRD | F_ARWR), 1'b1, 1'b0);
      step("fetch_ipc3", ev(S_INC_PC3, 0, A_PASS, F_VMA | F_IWR), 1'b1, 1'b0);
      set_instr(mk(5'b10001, 3'd3, 3'd6, 3'd0));
      step("exec", ev(S_EXEC, 0, A_PASS, '0), 1'b1, 1'b0);

      // BRC not taken: two PC increments before fetch
      step("brc2", ev(S_BRC2, 6, A_PASS, F_RRD | F_OPWR), 1'b1, 1'b1);
      step("brc3_nt", ev(S_BRC3, 0, A_PASS, F_RRD), 1'b1, 1'b0);
      step("skip_inc_pc", ev(S_INC_PC, 0, A_INC, F_PCRD | F_ORWR), 1'b1, 1'b0);
      step("skip_inc_pc2", ev(S_INC_PC2, 0, A_PASS, F_ORRD | F_PCWR | F_ARWR), 1'b1, 1'b0);
      fetch_tail(mk(5'b00011, 3'd1, 3'd7, 3'd0));

      step("mov1", ev(S_MOV1, 7, A_PASS, F_RRD | F_ORWR), 1'b1, 1'b0);
      step("mov2", ev(S_MOV2, 0, A_PASS, F_ORRD | F_RWR), 1'b1, 1'b0);
      fetch_tail(mk(5'b00100, 3'd4, 3'd0, 3'd3));

      step("ldi2", ev(S_LDI2, 0, A_INC, F_PCRD | F_ORWR), 1'b1, 1'b0);
      step("ldi3", ev(S_LDI3, 0, A_PASS, F_ORRD | F_PCWR | F_ARWR), 1'b1, 1'b0);
      step("ldi4", ev(S_LDI4, 3, A_PASS, F_VMA | F_RWR), 1'b1, 1'b0);
      fetch_tail(mk(5'b00111, 3'd6, 3'd1, 3'd4));

      step("inc2", ev(S_INC2, 4, A_INC, F_RRD | F_ORWR), 1'b1, 1'b0);
      step("inc3", ev(S_INC3, 4, A_PASS, F_ORRD | F_RWR), 1'b1, 1'b0);
      fetch_tail(mk(5'b01010, 3'd0, 3'd0, 3'd0));

      // Undefined opcode behaves as NOP
      fetch_tail(mk(5'b00000, 3'd0, 3'd0, 3'd0));
      fetch_tail(mk(5'b00010, 3'd5, 3'd1, 3'd2));

      // Reset mid-store while waiting on memory
      step("st2", ev(S_ST2, 2, A_PASS, F_RRD | F_ARWR), 1'b1, 1'b0);
      step("st3_wait", ev(S_ST3, 1, A_PASS, F_RRD | F_VMA | F_RW), 1'b0, 1'b0);
      reset = 1'b1;
      step("st3_reset", ev(S_RST1, 0, A_ZERO, F_ORWR), 1'b0, 1'b0);
      reset = 1'b0;
      set_instr(16'h0000);
      reset_seq();

      // Memory timeout during instruction fetch
      step("inc_pc", ev(S_INC_PC, 0, A_INC, F_PCRD | F_ORWR), 1'b1, 1'b0);
      step("inc_pc2", ev(S_INC_PC2, 0, A_PASS, F_ORRD | F_PCWR | F_ARWR), 1'b1, 1'b0);
      for (int i = 0; i < 15; i++) step("ipc3_stall", ev(S_INC_PC3, 0, A_PASS, F_VMA), 1'b0, 1'b0);
      step("timeout_halt", ev(S_HALT, 0, A_PASS, F_HLT | F_MF), 1'b0, 1'b0);
      step("halt_stays", ev(S_HALT, 0, A_PASS, F_HLT | F_MF), 1'b1, 1'b0);
      reset = 1'b1;
      step("fault_reset", ev(S_RST1, 0, A_ZERO, F_ORWR), 1'b1, 1'b0);
      set_instr(mk(5'b11111, 3'd2, 3'd0, 3'd0));
      reset = 1'b0;
      reset_seq();

      // HALT instruction
      step("halt_instr", ev(S_HALT, 0, A_PASS, F_HLT), 1'b1, 1'b0);
      step("halt_hold", ev(S_HALT, 0, A_PASS, F_HLT), 1'b1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
